// File: rtl/mdu_sched_pkg.sv
// Shared CPU definitions for the multiply/divide unit: E-stage op codes, default
// latencies, and the D-stage controller's opcode/funct constants.
package mdu_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  // D-stage decode: instruction word fields -> "is an MDU op".
  function automatic logic is_md_instr(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) &&
           (funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched_arith.sv
// Combinational MDU datapath: 64-bit product or quotient/remainder for the E-stage op.
// Zero latency; no flow control (the scheduler decides when results are captured).
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic        is_signed_mul;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign is_signed_mul = (op == MD_MULT);
  assign mul_a = {(is_signed_mul ? {32{rs[31]}} : 32'h0), rs};
  assign mul_b = {(is_signed_mul ? {32{rt[31]}} : 32'h0), rt};
  assign prod  = mul_a * mul_b;

  logic        is_signed_div;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
  assign is_signed_div = (op == MD_DIV);
  assign neg_a = is_signed_div & rs[31];
  assign neg_b = is_signed_div & rt[31];
  assign mag_a = neg_a ? (32'h0 - rs) : rs;
  assign mag_b = neg_b ? (32'h0 - rt) : rt;
  assign dvs   = (rt == 32'h0) ? 32'h1 : mag_b;
  assign q_mag = mag_a / dvs;
  assign r_mag = mag_a % dvs;
  assign quot  = (neg_a ^ neg_b) ? (32'h0 - q_mag) : q_mag;
  assign rem   = neg_a ? (32'h0 - r_mag) : r_mag;

  always_comb begin
    hi   = 32'h0;
    lo   = 32'h0;
    div0 = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: {hi, lo} = prod;
      MD_DIV, MD_DIVU: begin
        hi   = rem;
        lo   = quot;
        div0 = (rt == 32'h0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler: results captured on start, committed to HI/LO after MULT_CYC/DIV_CYC
// busy cycles; D-stage MDU ops stall while a start is issuing or the unit is busy.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_is_md,
  output logic        E_start,
  output logic        busy,
  output logic        D_md_stall,
  output logic [31:0] E_md_rdata
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  mdu_state_t  state;
  mdu_state_t  state_nxt;
  logic        commit;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_div0;
  logic [31:0] a_hi;
  logic [31:0] a_lo;
  logic        a_div0;
  logic        start_is_mult;

  mdu_arith u_arith (
    .op   (E_md_op),
    .rs   (E_rs_val),
    .rt   (E_rt_val),
    .hi   (a_hi),
    .lo   (a_lo),
    .div0 (a_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    E_start   = 1'b0;
    commit    = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (is_md_start(E_md_op)) begin
          E_start   = 1'b1;
          state_nxt = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        // Counter reaches zero on this edge: leave BUSY and commit together.
        if (cnt == CW'(1)) begin
          commit    = 1'b1;
          state_nxt = MDU_IDLE;
        end
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  assign busy          = (state == MDU_BUSY);
  assign D_md_stall    = D_is_md & (E_start | busy);
  assign start_is_mult = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU);

  always_comb begin
    E_md_rdata = 32'h0;
    if (E_md_op == MD_MFHI)      E_md_rdata = hi;
    else if (E_md_op == MD_MFLO) E_md_rdata = lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi        <= 32'h0;
      lo        <= 32'h0;
      pend_hi   <= 32'h0;
      pend_lo   <= 32'h0;
      pend_div0 <= 1'b0;
      cnt       <= '0;
    end else if (E_start) begin
      pend_hi   <= a_hi;
      pend_lo   <= a_lo;
      pend_div0 <= a_div0;
      cnt       <= start_is_mult ? CW'(MULT_CYC) : CW'(DIV_CYC);
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      // A zero divisor still burns the full latency but leaves HI/LO untouched.
      if (commit && !pend_div0) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (E_md_op == MD_MTHI) begin
      hi <= E_rs_val;
    end else if (E_md_op == MD_MTLO) begin
      lo <= E_rs_val;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized and directed checks of mdu_sched against a cycle-level reference model.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int T_MULT = 5;
  localparam int T_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        D_is_md;
  logic        E_start;
  logic        busy;
  logic        D_md_stall;
  logic [31:0] E_md_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mdu_sched #(.MULT_CYC(T_MULT), .DIV_CYC(T_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .D_is_md    (D_is_md),
    .E_start    (E_start),
    .busy       (busy),
    .D_md_stall (D_md_stall),
    .E_md_rdata (E_md_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO, a pending result and cycles left busy.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pok;
  int          m_left;

  function automatic void m_reset();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
  endfunction

  function automatic logic m_is_start(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic logic m_start();
    return m_is_start(E_md_op) && (m_left == 0);
  endfunction

  function automatic logic [31:0] m_rdata();
    if (E_md_op == MD_MFHI) return m_hi;
    if (E_md_op == MD_MFLO) return m_lo;
    return 32'h0;
  endfunction

  function automatic void m_clk();
    longint          a_s, b_s, q_s, r_s;
    longint unsigned a_u, b_u, p_u, q_u, r_u;
    a_s = $signed(E_rs_val);
    b_s = $signed(E_rt_val);
    a_u = {32'h0, E_rs_val};
    b_u = {32'h0, E_rt_val};
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (m_is_start(E_md_op)) begin
      m_pok  = 1'b1;
      m_left = (E_md_op == MD_MULT || E_md_op == MD_MULTU) ? T_MULT : T_DIV;
      case (E_md_op)
        MD_MULT:  begin p_u = a_s * b_s; {m_phi, m_plo} = p_u; end
        MD_MULTU: begin p_u = a_u * b_u; {m_phi, m_plo} = p_u; end
        MD_DIV: begin
          if (b_s == 0) m_pok = 1'b0;
          else begin q_s = a_s / b_s; r_s = a_s % b_s; m_plo = q_s[31:0]; m_phi = r_s[31:0]; end
        end
        default: begin
          if (b_u == 0) m_pok = 1'b0;
          else begin q_u = a_u / b_u; r_u = a_u % b_u; m_plo = q_u[31:0]; m_phi = r_u[31:0]; end
        end
      endcase
    end else if (E_md_op == MD_MTHI) m_hi = E_rs_val;
    else if (E_md_op == MD_MTLO) m_lo = E_rs_val;
  endfunction

  task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic d);
    @(negedge clk);
    E_md_op = op; E_rs_val = rs; E_rt_val = rt; D_is_md = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(MD_NONE, 32'h0, 32'h0, 1'b0);
      m_clk();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; E_md_op = MD_MULT; E_rs_val = 32'h0; E_rt_val = 32'h0; D_is_md = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (E_start !== 1'b1) begin n_fail++; $display("FAIL reset_start got %b exp 1", E_start); end
    n_chk++; if (D_md_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b exp 1", D_md_stall); end
    E_md_op = MD_MFHI; #1;
    n_chk++; if (E_md_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", E_md_rdata); end
    E_md_op = MD_MFLO; #1;
    n_chk++; if (E_md_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", E_md_rdata); end
    E_md_op = MD_NONE; D_is_md = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult();
    cyc(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    n_chk++; if (E_start !== 1'b1) begin n_fail++; $display("FAIL mult_start got %b exp 1", E_start); end
    m_clk();
    for (int i = 0; i < T_MULT; i++) begin
      cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy[%0d] got %b exp 1", i, busy); end
      n_chk++; if (E_start !== 1'b0) begin n_fail++; $display("FAIL mult_nostart[%0d] got %b exp 0", i, E_start); end
      n_chk++; if (E_md_rdata !== m_lo) begin n_fail++; $display("FAIL mult_pending_hidden got %h exp %h", E_md_rdata, m_lo); end
      m_clk();
    end
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_done got %b exp 0", busy); end
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h exp ffffffff", E_md_rdata); end
    m_clk();
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h exp fffffffa", E_md_rdata); end
    m_clk();
    cyc(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0); m_clk();
    idle(T_MULT);
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi got %h exp 00000002", E_md_rdata); end
    m_clk();
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo got %h exp fffffffa", E_md_rdata); end
    m_clk();
  endtask

  task automatic test_div();
    cyc(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0); m_clk();
    for (int i = 0; i < T_DIV; i++) begin
      cyc(MD_NONE, 32'h0, 32'h0, 1'b0);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy[%0d] got %b exp 1", i, busy); end
      m_clk();
    end
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div_done got %b exp 0", busy); end
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h exp fffffffd", E_md_rdata); end
    m_clk();
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h exp ffffffff", E_md_rdata); end
    m_clk();
    // Divide by zero, signed then unsigned: full latency, HI/LO kept.
    cyc(MD_DIV, 32'd1234, 32'h0, 1'b0); m_clk();
    idle(T_DIV - 1);
    cyc(MD_NONE, 32'h0, 32'h0, 1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div0_last_busy got %b exp 1", busy); end
    m_clk();
    cyc(MD_DIVU, 32'd99, 32'h0, 1'b0);
    n_chk++; if (E_start !== 1'b1) begin n_fail++; $display("FAIL divu0_start got %b exp 1", E_start); end
    m_clk();
    idle(T_DIV);
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div0_lo got %h exp fffffffd", E_md_rdata); end
    m_clk();
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_hi got %h exp ffffffff", E_md_rdata); end
    m_clk();
    cyc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); m_clk();
    idle(T_DIV);
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h exp 80000000", E_md_rdata); end
    m_clk();
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi got %h exp 00000000", E_md_rdata); end
    m_clk();
  endtask

  task automatic test_stall();
    cyc(MD_MULT, 32'd5, 32'd6, 1'b1);
    n_chk++; if (D_md_stall !== 1'b1) begin n_fail++; $display("FAIL stall_start got %b exp 1", D_md_stall); end
    m_clk();
    for (int i = 0; i < T_MULT; i++) begin
      cyc(MD_NONE, 32'h0, 32'h0, 1'b1);
      n_chk++; if (D_md_stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d] got %b exp 1", i, D_md_stall); end
      m_clk();
    end
    cyc(MD_NONE, 32'h0, 32'h0, 1'b1);
    n_chk++; if (D_md_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b exp 0", D_md_stall); end
    m_clk();
  endtask

  task automatic test_mt_mf();
    cyc(MD_MTLO, 32'h0000_1234, 32'h0, 1'b0); m_clk();
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_mflo got %h exp 00001234", E_md_rdata); end
    m_clk();
    cyc(MD_MTHI, 32'h5555_AAAA, 32'h0, 1'b0); m_clk();
    // Zero-divisor op keeps HI, so any write seen afterwards came from the ignored ops.
    cyc(MD_DIVU, 32'd7, 32'h0, 1'b0); m_clk();
    for (int i = 0; i < T_DIV; i++) begin
      cyc((i % 2 == 0) ? MD_MTHI : MD_MULT, 32'hDEAD_BEEF, 32'd3, 1'b0);
      n_chk++; if (E_start !== 1'b0) begin n_fail++; $display("FAIL busy_restart[%0d] got %b exp 0", i, E_start); end
      m_clk();
    end
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_ops_len got %b exp 0", busy); end
    n_chk++; if (E_md_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL mthi_while_busy got %h exp 5555aaaa", E_md_rdata); end
    m_clk();
  endtask

  task automatic test_back_to_back();
    cyc(MD_MULT, 32'd7, 32'd9, 1'b0); m_clk();
    idle(T_MULT);
    cyc(MD_DIVU, 32'd100, 32'd7, 1'b0);
    n_chk++; if (E_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start got %b exp 1", E_start); end
    m_clk();
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'd63) begin n_fail++; $display("FAIL b2b_first_commit got %h exp 0000003f", E_md_rdata); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
    m_clk();
    idle(T_DIV - 1);
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'd14) begin n_fail++; $display("FAIL b2b_divu_lo got %h exp 0000000e", E_md_rdata); end
    m_clk();
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== 32'd2) begin n_fail++; $display("FAIL b2b_divu_hi got %h exp 00000002", E_md_rdata); end
    m_clk();
  endtask

  task automatic test_reset_mid();
    cyc(MD_MTHI, 32'hAAAA_5555, 32'h0, 1'b0); m_clk();
    cyc(MD_DIV, 32'd100, 32'd3, 1'b0); m_clk();
    idle(2);
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy3 got %b exp 1", busy); end
    reset = 1'b1; #1;
    m_reset();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_clear got %b exp 0", busy); end
    n_chk++; if (E_md_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_hi_clear got %h exp 0", E_md_rdata); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < T_DIV + 2; i++) begin
      cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
      n_chk++; if (busy !== 1'b0 || E_md_rdata !== 32'h0) begin
        n_fail++; $display("FAIL rmid_no_commit[%0d] got busy=%b lo=%h exp busy=0 lo=0", i, busy, E_md_rdata);
      end
      m_clk();
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        d, e_start, e_busy;
    for (int i = 0; i < 500; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom();
      rt = $urandom();
      case ($urandom_range(0, 7))
        0: rt = 32'h0;
        1: rt = 32'hFFFF_FFFF;
        2: rs = 32'h8000_0000;
        3: rt = 32'($urandom_range(1, 20));
        default: ;
      endcase
      d = 1'($urandom_range(0, 1));
      cyc(op, rs, rt, d);
      e_start = m_start();
      e_busy  = (m_left > 0);
      n_chk++; if (E_start !== e_start) begin n_fail++; $display("FAIL rnd_start[%0d] got %b exp %b", i, E_start, e_start); end
      n_chk++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy[%0d] got %b exp %b", i, busy, e_busy); end
      n_chk++; if (D_md_stall !== (d & (e_start | e_busy))) begin
        n_fail++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, D_md_stall, d & (e_start | e_busy));
      end
      n_chk++; if (E_md_rdata !== m_rdata()) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h exp %h", i, E_md_rdata, m_rdata()); end
      m_clk();
    end
    idle(T_DIV + 1);
    cyc(MD_MFHI, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== m_hi) begin n_fail++; $display("FAIL rnd_final_hi got %h exp %h", E_md_rdata, m_hi); end
    m_clk();
    cyc(MD_MFLO, 32'h0, 32'h0, 1'b0);
    n_chk++; if (E_md_rdata !== m_lo) begin n_fail++; $display("FAIL rnd_final_lo got %h exp %h", E_md_rdata, m_lo); end
    m_clk();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt_mf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles after a mult/multu start.
REQ-002 Parameter DIV_CYC, default 10, busy cycles after a div/divu start.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 E_md_op  input  4  E-stage MDU operation code (package enum: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
REQ-006 E_rs_val  input  32  forwarded rs operand in E.
REQ-007 E_rt_val  input  32  forwarded rt operand in E.
REQ-008 D_is_md  input  1  D-stage instruction is any MDU op (decoded by the D-stage controller).
REQ-009 E_start  output  1  combinational; E_md_op is MULT/MULTU/DIV/DIVU and unit not busy.
REQ-010 busy  output  1  registered; operation in flight.
REQ-011 D_md_stall  output  1  combinational; D_is_md & (E_start | busy).
REQ-012 E_md_rdata  output  32  combinational; HI for MFHI, LO for MFLO, else 0.

Function
REQ-013 On E_start, the unit SHALL capture the full 64-bit result into pending registers and load the counter with MULT_CYC or DIV_CYC.
REQ-014 busy SHALL be high exactly N cycles starting the cycle after E_start (N = MULT_CYC or DIV_CYC).
REQ-015 The counter SHALL decrement once per cycle while busy; on the edge where it reaches 0, busy SHALL fall and pending SHALL commit to HI/LO in that same edge.
REQ-016 MULT: {HI,LO} = signed rs*rt; MULTU: unsigned 64-bit product.
REQ-017 DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign; DIVU: unsigned.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero (either signedness) SHALL still run DIV_CYC busy cycles and SHALL leave HI/LO unchanged at commit.
REQ-020 MTHI/MTLO SHALL write E_rs_val to HI/LO at the next edge, only when not busy; while busy they SHALL be ignored (pipeline stall prevents this).
REQ-021 MFHI/MFLO SHALL read committed HI/LO; they never observe pending values.
REQ-022 E_md_op of MULT/DIV class while busy SHALL be ignored (no restart, counter unaffected).
REQ-023 Back-to-back: a new start is legal in the cycle busy has just fallen; the result committed in that edge SHALL be the previous operation's.
REQ-024 State machine: IDLE -> BUSY on E_start; BUSY -> IDLE when counter reaches 0; BUSY is the only non-idle state.
REQ-025 E_md_op NONE and unknown codes SHALL change no state.

Reset
REQ-026 Reset SHALL set HI=0, LO=0, pending=0, counter=0, state=IDLE, busy=0.
REQ-027 Reset mid-operation SHALL abort the operation with no commit; E_start may assert the cycle after reset deasserts.
REQ-028 With reset high all combinational outputs SHALL follow from the cleared state (D_md_stall = D_is_md & E_start).

Structure
REQ-029 The md_op enum and MULT_CYC/DIV_CYC defaults SHALL live in the shared CPU package, with the D-stage controller's opcode constants.
REQ-030 Arithmetic SHALL be isolated in one sub-module, mdu_arith (combinational: op, rs, rt -> hi, lo, div0).
REQ-031 Counter width SHALL be clog2(max(MULT_CYC,DIV_CYC)+1) bits.

Verification
REQ-032 MULT rs=0xFFFFFFFE rt=3 -> E_start 1 cycle, busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-033 MULTU same operands -> HI=0x00000002 LO=0xFFFFFFFA after 5 busy cycles.
REQ-034 DIV rs=-7 rt=2 -> 10 busy cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; DIV by 0 -> HI/LO unchanged.
REQ-035 D_is_md=1 during E_start and all busy cycles -> D_md_stall=1 each cycle, 0 the cycle busy falls.
REQ-036 Reset asserted at busy cycle 3 of DIV -> busy=0 immediately, HI=LO=0, no later commit.
REQ-037 MTLO 0x1234 then MFLO next cycle -> E_md_rdata=0x00001234; MTHI while busy -> HI unchanged.
